instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameters, one per line:
- ADDRESS_BITWIDTH, 8, byte-address width; equals the cache's ADDRESS_BITWIDTH.
- INSTRUCTION_BITWIDTH, 32, instruction width.
- QUEUE_DEPTH_BITWIDTH, 2, log2 of fetch-queue entries (4).
- RESET_PC, 0, first fetch address.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock. Reset is synchronous and active-high.
- rst, in, 1, synchronous active-high reset.
- ic_addr, out, ADDRESS_BITWIDTH, registered address to the cache's addrB.
- ic_dout, in, INSTRUCTION_BITWIDTH, the cache's doutB.
- ic_rdy, in, 1, the cache's rdyB.
- ic_bsy, in, 1, the cache's bsyB (line fill in progress).
- redirect, in, 1, branch/jump: restart fetch.
- redirect_pc, in, ADDRESS_BITWIDTH, new fetch address.
- out_valid, out, 1, queue head valid.
- out_ready, in, 1, decoder accepts head.
- out_pc, out, ADDRESS_BITWIDTH, address of head instruction.
- out_instr, out, INSTRUCTION_BITWIDTH, head instruction.

Function
REQ-003 SHALL keep ic_addr stable while in S_SETTLE or S_WAIT, and SHALL change it only in a cycle where ic_bsy=0.
REQ-004 SHALL implement states S_SETTLE, S_WAIT and S_DRAIN.
- S_SETTLE: lasts one cycle after any ic_addr change; ic_rdy ignored; next state S_WAIT.
- S_WAIT: on ic_rdy=1 with push allowed, push {pc, ic_dout} and set pc<=pc+4. Then, if ic_bsy=1, go to S_DRAIN; otherwise set ic_addr<=pc+4 and go to S_SETTLE. Stay in S_WAIT if ic_rdy=0 or push is not allowed.
- S_DRAIN: wait for ic_bsy=0, then set ic_addr<=pc and go to S_SETTLE.
REQ-005 Push is allowed when the queue is not full, or when out_valid&&out_ready in the same cycle (full queue with simultaneous pop and push holds count constant).
REQ-006 pc arithmetic SHALL be modulo 2^ADDRESS_BITWIDTH; the wrap from max to 0 is legal with no flag.
REQ-007 redirect SHALL, in any state:
- flush the queue (out_valid=0 next cycle);
- set pc<=redirect_pc with bits[1:0] forced to 0;
- if ic_bsy=1, go to S_DRAIN; otherwise set ic_addr<=the aligned redirect_pc and go to S_SETTLE.
REQ-008 redirect SHALL win over a simultaneous push (push discarded) and over a simultaneous pop (queue flushed regardless).
REQ-009 The queue SHALL be a FIFO with wrapping read/write pointers and an occupancy count of 0..2^QUEUE_DEPTH_BITWIDTH.
- out_valid = (count!=0).
- out_pc and out_instr are the head entry, stable while out_valid&&!out_ready.
REQ-010 Hit latency: an instruction is pushed 2 cycles after its ic_addr update; out_valid rises the cycle after the push.

Reset
REQ-011 On rst at a clk edge:
- pc=RESET_PC, ic_addr=RESET_PC, state=S_SETTLE;
- queue empty, out_valid=0, out_pc=0, out_instr=0;
- counters (if compiled in) = 0.
REQ-012 Reset mid-fill SHALL abandon the fill without waiting on ic_bsy. The cache shares rst.

Configuration
REQ-013 With FETCH_PERF_COUNTERS_EN defined, SHALL add two 32-bit output ports:
- stall_cycles: counts cycles in S_WAIT with ic_rdy=0, plus all S_DRAIN cycles.
- fetch_count: counts pushes.
Both saturate at all-ones. Without the macro, these ports and their logic SHALL be absent.

Structure
REQ-014 A shared package SHALL hold:
- state encodings S_SETTLE, S_WAIT, S_DRAIN;
- INSTRUCTION_BYTES=4.
REQ-015 The queue SHALL be a sub-module, fetch_queue (parameterised width/depth, push/pop/flush, full/empty/count).

Verification
Bench instantiates instruction_fetch + Cache (1 line-ix bit, 3 ix-in-line bits) + BurstRAM with the standard RAM.mem.
REQ-016 Reset release, out_ready=1:
- queue SHALL yield {0,B7C6A980}, then {4,3F5A2E14}, then {8,AB4C3E6F}, in order;
- no push SHALL occur while ic_bsy=1 changes ic_addr.
REQ-017 out_ready=0 held: queue SHALL fill to 4 entries, stay in S_WAIT, and hold out_pc=0.
- Release out_ready: pc values 0,4,8,C SHALL come out in order with no loss or duplicate.
REQ-018 redirect to 0x42 during the fill of line 0:
- the next out_valid SHALL be out_pc=0x40, out_instr=4E5F6A7B;
- ic_addr SHALL NOT change before ic_bsy=0.
REQ-019 redirect to 0x20 after 0x40 is fetched (evicting line 0):
- the head SHALL be {0x20,2F5E3C7A};
- redirect in the same cycle as a push SHALL leave no stale entry.
REQ-020 redirect to 0xFC, out_ready=1: the pc sequence SHALL be FC, then 00 (wrap).
- Assert rst mid-fill: the next cycle SHALL show out_valid=0 and ic_addr=RESET_PC.
- With FETCH_PERF_COUNTERS_EN: fetch_count SHALL equal the number of pushes, and stall_cycles SHALL be nonzero after the first miss.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings
// and the fixed instruction size used for pc stepping.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_WAIT   = 2'd1,
    S_DRAIN  = 2'd2
  } fetch_state_e;

  localparam int INSTRUCTION_BYTES = 4;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO of {pc, instruction} entries with wrapping
// read/write pointers and an explicit occupancy count (0..2^DEPTH_BITWIDTH).
// A pop on a full queue frees the slot for a push in the same cycle.
// Flush empties the queue and takes priority over push and pop.
module fetch_queue #(
  parameter int WIDTH          = 40,
  parameter int DEPTH_BITWIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [WIDTH-1:0]        data_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [DEPTH_BITWIDTH:0] count_o
);

  localparam int DEPTH = 1 << DEPTH_BITWIDTH;

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [DEPTH_BITWIDTH-1:0] wr_ptr_q;
  logic [DEPTH_BITWIDTH-1:0] rd_ptr_q;
  logic [DEPTH_BITWIDTH:0]   count_q;
  logic                      do_push;
  logic                      do_pop;

  assign full_o  = (count_q == (DEPTH_BITWIDTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping; flush behaves like a reset.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks pc through the instruction cache's B port,
// buffering {pc, instruction} pairs in a small queue for the decoder.
// ic_addr only moves while the cache is idle (ic_bsy=0); S_SETTLE gives the
// cache one cycle to register a new address before ic_rdy is trusted.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating stall_cycles
// and fetch_count outputs.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                          ADDRESS_BITWIDTH     = 8,
  parameter int                          INSTRUCTION_BITWIDTH = 32,
  parameter int                          QUEUE_DEPTH_BITWIDTH = 2,
  parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC             = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic [ADDRESS_BITWIDTH-1:0]     ic_addr,
  input  logic [INSTRUCTION_BITWIDTH-1:0] ic_dout,
  input  logic                            ic_rdy,
  input  logic                            ic_bsy,
  input  logic                            redirect,
  input  logic [ADDRESS_BITWIDTH-1:0]     redirect_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ADDRESS_BITWIDTH-1:0]     out_pc,
  output logic [INSTRUCTION_BITWIDTH-1:0] out_instr
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]                     stall_cycles,
  output logic [31:0]                     fetch_count
`endif
);

  localparam int ENTRY_W = ADDRESS_BITWIDTH + INSTRUCTION_BITWIDTH;

  fetch_state_e                  state_q;
  logic [ADDRESS_BITWIDTH-1:0]   pc_q;
  logic [ADDRESS_BITWIDTH-1:0]   ic_addr_q;
  logic [ADDRESS_BITWIDTH-1:0]   pc_inc;
  logic [ADDRESS_BITWIDTH-1:0]   redirect_aligned;
  logic                          push_ok;
  logic                          push_en;
  logic [ENTRY_W-1:0]            q_head;
  logic                          q_full;
  logic                          q_empty;
  logic [QUEUE_DEPTH_BITWIDTH:0] q_count;

  // Modulo 2^ADDRESS_BITWIDTH: wrapping past the top of memory is intended.
  assign pc_inc           = pc_q + ADDRESS_BITWIDTH'(INSTRUCTION_BYTES);
  assign redirect_aligned = {redirect_pc[ADDRESS_BITWIDTH-1:2], 2'b00};

  assign out_valid = (q_count != '0);
  assign push_ok   = !q_full || (out_valid && out_ready);
  assign push_en   = (state_q == S_WAIT) && ic_rdy && push_ok && !redirect;

  assign ic_addr   = ic_addr_q;
  assign out_pc    = q_empty ? '0 : q_head[ENTRY_W-1:INSTRUCTION_BITWIDTH];
  assign out_instr = q_empty ? '0 : q_head[INSTRUCTION_BITWIDTH-1:0];

  fetch_queue #(
    .WIDTH          (ENTRY_W),
    .DEPTH_BITWIDTH (QUEUE_DEPTH_BITWIDTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_en),
    .data_i  ({pc_q, ic_dout}),
    .pop_i   (out_ready),
    .flush_i (redirect),
    .data_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  // Fetch FSM: redirect overrides everything; reset abandons any fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SETTLE;
      pc_q      <= RESET_PC;
      ic_addr_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_aligned;
      if (ic_bsy) begin
        state_q <= S_DRAIN;
      end else begin
        ic_addr_q <= redirect_aligned;
        state_q   <= S_SETTLE;
      end
    end else begin
      case (state_q)
        S_SETTLE: state_q <= S_WAIT;
        S_WAIT: begin
          if (ic_rdy && push_ok) begin
            pc_q <= pc_inc;
            if (ic_bsy) begin
              state_q <= S_DRAIN;
            end else begin
              ic_addr_q <= pc_inc;
              state_q   <= S_SETTLE;
            end
          end
        end
        S_DRAIN: begin
          if (!ic_bsy) begin
            ic_addr_q <= pc_q;
            state_q   <= S_SETTLE;
          end
        end
        default: state_q <= S_SETTLE;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_q;
  logic [31:0] fetch_q;

  assign stall_cycles = stall_q;
  assign fetch_count  = fetch_q;

  // Saturating counters: cycles lost waiting on the cache, and pushes made.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      fetch_q <= '0;
    end else begin
      if (((state_q == S_WAIT) && !ic_rdy) || (state_q == S_DRAIN)) begin
        if (stall_q != '1) stall_q <= stall_q + 1'b1;
      end
      if (push_en && (fetch_q != '1)) fetch_q <= fetch_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a small behavioural cache:
// 2 lines x 8 words, 8-cycle line fill, critical word offered mid-fill.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ic_addr;
  logic [31:0] ic_dout;
  logic        ic_rdy;
  logic        ic_bsy;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_cycles;
  logic [31:0] fetch_count;
`endif

  int checks   = 0;
  int failures = 0;
  int viol     = 0;

  logic [7:0]  pq_pc [$];
  logic [31:0] pq_in [$];

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDRESS_BITWIDTH     (8),
    .INSTRUCTION_BITWIDTH (32),
    .QUEUE_DEPTH_BITWIDTH (2),
    .RESET_PC             (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ic_addr     (ic_addr),
    .ic_dout     (ic_dout),
    .ic_rdy      (ic_rdy),
    .ic_bsy      (ic_bsy),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .stall_cycles (stall_cycles),
    .fetch_count  (fetch_count)
`endif
  );

  // Memory image: a few fixed words, the rest a simple address pattern.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 32'hB7C6A980;
      8'h04:   return 32'h3F5A2E14;
      8'h08:   return 32'hAB4C3E6F;
      8'h20:   return 32'h2F5E3C7A;
      8'h40:   return 32'h4E5F6A7B;
      default: return {a, ~a, a ^ 8'h5A, 8'hC3};
    endcase
  endfunction

  // Cache model: line = addr[5], tag = addr[7:6]; registered rdy/dout.
  logic       c_vld [2];
  logic [1:0] c_tag [2];
  int         fcnt;
  logic       fline;
  logic [1:0] ftag;

  always @(posedge clk) begin
    if (rst) begin
      c_vld[0] <= 1'b0;
      c_vld[1] <= 1'b0;
      ic_bsy   <= 1'b0;
      ic_rdy   <= 1'b0;
      ic_dout  <= 32'h0;
      fcnt     <= 0;
    end else begin
      ic_dout <= mem_word(ic_addr);
      if (ic_bsy) begin
        ic_rdy <= (fcnt <= 4) && (ic_addr[5] == fline) && (ic_addr[7:6] == ftag);
        if (fcnt == 0) begin
          ic_bsy       <= 1'b0;
          c_vld[fline] <= 1'b1;
          c_tag[fline] <= ftag;
        end else begin
          fcnt <= fcnt - 1;
        end
      end else if (c_vld[ic_addr[5]] && (c_tag[ic_addr[5]] == ic_addr[7:6])) begin
        ic_rdy <= 1'b1;
      end else begin
        ic_rdy            <= 1'b0;
        ic_bsy            <= 1'b1;
        fcnt              <= 7;
        fline             <= ic_addr[5];
        ftag              <= ic_addr[7:6];
        c_vld[ic_addr[5]] <= 1'b0;
      end
    end
  end

  // Records any ic_addr movement across an edge where the cache was busy.
  logic [7:0] mon_a;
  logic       mon_b;
  logic       mon_r;
  always begin
    @(posedge clk);
    mon_a = ic_addr;
    mon_b = ic_bsy;
    mon_r = rst;
    #1;
    if (mon_r === 1'b0 && mon_b === 1'b1 && ic_addr !== mon_a) viol++;
  end

  // Decoder side: log every accepted head entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && redirect === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      pq_pc.push_back(out_pc);
      pq_in.push_back(out_instr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic clear_pops();
    pq_pc.delete();
    pq_in.delete();
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int i = 0;
    while (pq_pc.size() < n && i < budget) begin
      step();
      i++;
    end
    chk(tag, 32'(pq_pc.size() >= n), 32'd1);
  endtask

  function automatic logic [7:0] ppc(input int i);
    return (i < pq_pc.size()) ? pq_pc[i] : 8'hxx;
  endfunction

  function automatic logic [31:0] pin(input int i);
    return (i < pq_in.size()) ? pq_in[i] : 32'hxxxxxxxx;
  endfunction

  initial begin
    logic [7:0] last_a;
    logic [7:0] last2_a;
    logic       found;

    // Reset state
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_ic_addr", ic_addr, 32'd0);

    // In-order stream from reset
    clear_pops();
    rst = 1'b0;
    wait_pops(3, 200, "t1_timeout");
    chk("t1_pc0", ppc(0), 32'h00);
    chk("t1_in0", pin(0), 32'hB7C6A980);
    chk("t1_pc1", ppc(1), 32'h04);
    chk("t1_in1", pin(1), 32'h3F5A2E14);
    chk("t1_pc2", ppc(2), 32'h08);
    chk("t1_in2", pin(2), 32'hAB4C3E6F);

    // Backpressure: queue fills and holds its head
    out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    clear_pops();
    rst = 1'b0;
    repeat (60) step();
    chk("t2_valid", out_valid, 32'd1);
    chk("t2_head_pc", out_pc, 32'h00);
    chk("t2_head_in", out_instr, 32'hB7C6A980);
    chk("t2_addr", ic_addr, 32'h10);
    repeat (5) step();
    chk("t2_addr_hold", ic_addr, 32'h10);
    chk("t2_head_hold", out_pc, 32'h00);
    chk("t2_no_pop", pq_pc.size(), 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("t2_fetch_count", fetch_count, 32'd4);
    chk("t2_stall_nonzero", 32'(stall_cycles != 32'd0), 32'd1);
`endif
    out_ready = 1'b1;
    wait_pops(5, 100, "t2_timeout");
    chk("t2_pc0", ppc(0), 32'h00);
    chk("t2_pc1", ppc(1), 32'h04);
    chk("t2_pc2", ppc(2), 32'h08);
    chk("t2_pc3", ppc(3), 32'h0C);
    chk("t2_in3", pin(3), 32'h0CF356C3);
    chk("t2_pc4", ppc(4), 32'h10);
    chk("t2_in4", pin(4), 32'h10EF4AC3);

    // Redirect to 0x42 while line 0 is filling
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 8'h42;
    step();
    redirect = 1'b0;
    clear_pops();
    chk("t3_flush_valid", out_valid, 32'd0);
    chk("t3_addr_held", ic_addr, 32'h00);
    wait_pops(1, 200, "t3_timeout");
    chk("t3_pc", ppc(0), 32'h40);
    chk("t3_in", pin(0), 32'h4E5F6A7B);

    // Redirect to 0x20 exactly on a push cycle
    last_a = ic_addr;
    last2_a = ic_addr;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (ic_rdy === 1'b1 && ic_bsy === 1'b0 && ic_addr == last_a && last_a != last2_a) begin
        found = 1'b1;
      end else begin
        last2_a = last_a;
        last_a = ic_addr;
      end
    end
    chk("t4_push_cycle_found", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_pc = 8'h20;
    step();
    redirect = 1'b0;
    clear_pops();
    chk("t4_no_stale", out_valid, 32'd0);
    chk("t4_addr", ic_addr, 32'h20);
    wait_pops(2, 200, "t4_timeout");
    chk("t4_pc0", ppc(0), 32'h20);
    chk("t4_in0", pin(0), 32'h2F5E3C7A);
    chk("t4_pc1", ppc(1), 32'h24);
    chk("t4_in1", pin(1), 32'h24DB7EC3);

    // Redirect to 0xFC: pc wraps to 0x00
    redirect = 1'b1;
    redirect_pc = 8'hFC;
    step();
    redirect = 1'b0;
    clear_pops();
    wait_pops(2, 200, "t5_timeout");
    chk("t5_pc0", ppc(0), 32'hFC);
    chk("t5_in0", pin(0), 32'hFC03A6C3);
    chk("t5_pc1", ppc(1), 32'h00);
    chk("t5_in1", pin(1), 32'hB7C6A980);

    // Reset in the middle of a fill
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (ic_bsy === 1'b1) found = 1'b1;
      else step();
    end
    chk("t6_fill_seen", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_valid", out_valid, 32'd0);
    chk("t6_addr", ic_addr, 32'h00);
    chk("t6_out_pc", out_pc, 32'h00);
    chk("t6_out_instr", out_instr, 32'h0);
    clear_pops();
    rst = 1'b0;
    wait_pops(1, 200, "t6_timeout");
    chk("t6_pc0", ppc(0), 32'h00);
    chk("t6_in0", pin(0), 32'hB7C6A980);

    chk("addr_moved_while_busy", viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
